hwag_coil_scheduler: RTL

Parametrised N-channel ignition coil scheduler for the HWAG angle generator. It takes the master angle counter and per-channel phase offsets, derives each channel's charge (dwell start) and ignition angles with modular wrap-around, and drives one coil output per channel. Angle sets are double-buffered so that firmware updates over SPI never tear an in-progress dwell. It sits between `hwag_core` (angle counter, `hwag_start`) and the coil pins, and replaces per-coil slave counters with offset arithmetic.

---
 rtl/hwag_coil_pkg.sv | 15 +
 rtl/hwag_coil_scheduler_if.sv | 32 +++
 rtl/hwag_coil_channel.sv | 112 +++++++++++
 rtl/hwag_coil_scheduler.sv | 38 +++
 4 files changed

// File: rtl/hwag_coil_pkg.sv
// Shared types and defaults for the HWAG ignition coil scheduler.
package hwag_coil_pkg;

  localparam int ACNT_WIDTH_DEF = 24;
  localparam int ACNT_MAX_DEF   = 3839;

  typedef logic [ACNT_WIDTH_DEF-1:0] acnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_FIRE   = 2'd2
  } coil_state_t;

endpackage

// File: rtl/hwag_coil_scheduler_if.sv
// Angle, update and coil signals between hwag_core/firmware and the coil scheduler.
interface hwag_coil_scheduler_if
  import hwag_coil_pkg::*;
#(
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int CHANNELS   = 2
);

  logic                           hwag_start;
  logic                           acnt_ena;
  logic [ACNT_WIDTH-1:0]          acnt_in;
  logic [CHANNELS*ACNT_WIDTH-1:0] phase_offset;
  logic                           upd_strobe;
  logic [ACNT_WIDTH-1:0]          ign_angle;
  logic [ACNT_WIDTH-1:0]          dwell_angle;
  logic [CHANNELS-1:0]            coil_out;
  logic [CHANNELS-1:0]            upd_pending;
  logic [CHANNELS-1:0]            angle_err;

  modport master (
    output hwag_start, acnt_ena, acnt_in, phase_offset,
    output upd_strobe, ign_angle, dwell_angle,
    input  coil_out, upd_pending, angle_err
  );

  modport slave (
    input  hwag_start, acnt_ena, acnt_in, phase_offset,
    input  upd_strobe, ign_angle, dwell_angle,
    output coil_out, upd_pending, angle_err
  );

endinterface

// File: rtl/hwag_coil_channel.sv
// One coil channel: offset angle, double-buffered ignition/charge angles and the
// IDLE/CHARGE/FIRE sequencer driving a registered coil output.
module hwag_coil_channel
  import hwag_coil_pkg::*;
#(
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int ACNT_MAX   = ACNT_MAX_DEF
)
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  hwag_start,
  input  logic                  acnt_ena,
  input  logic [ACNT_WIDTH-1:0] acnt_in,
  input  logic [ACNT_WIDTH-1:0] phase_offset,
  input  logic                  upd_strobe,
  input  logic [ACNT_WIDTH-1:0] ign_angle,
  input  logic [ACNT_WIDTH-1:0] dwell_angle,
  output logic                  coil_out,
  output logic                  upd_pending,
  output logic                  angle_err
);

  localparam logic [ACNT_WIDTH:0]   MAX_X = (ACNT_WIDTH+1)'(ACNT_MAX);
  localparam logic [ACNT_WIDTH:0]   REV_X = (ACNT_WIDTH+1)'(ACNT_MAX + 1);
  localparam logic [ACNT_WIDTH-1:0] MAX_W = ACNT_WIDTH'(ACNT_MAX);
  localparam logic [ACNT_WIDTH-1:0] REV_W = ACNT_WIDTH'(ACNT_MAX + 1);

  logic [ACNT_WIDTH:0]   ch_sum;
  logic [ACNT_WIDTH-1:0] ch_angle;
  logic [ACNT_WIDTH-1:0] dwell_sat;
  logic [ACNT_WIDTH-1:0] charge_new;
  logic                  ign_ok;

  logic [ACNT_WIDTH-1:0] shd_ign_reg, shd_charge_reg;
  logic [ACNT_WIDTH-1:0] act_ign_reg, act_charge_reg;
  logic                  shd_valid_reg, act_valid_reg;
  coil_state_t           state_reg;

  // Results are bounded by ACNT_MAX, so plain ACNT_WIDTH modular arithmetic is exact here.
  always_comb begin
    ch_sum     = {1'b0, acnt_in} + {1'b0, phase_offset};
    ch_angle   = (ch_sum > MAX_X) ? ACNT_WIDTH'(ch_sum - REV_X) : ACNT_WIDTH'(ch_sum);
    dwell_sat  = (dwell_angle > MAX_W) ? MAX_W : dwell_angle;
    charge_new = (ign_angle >= dwell_sat) ? (ign_angle - dwell_sat)
                                          : (ign_angle + REV_W - dwell_sat);
    ign_ok     = (ign_angle <= MAX_W);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shd_ign_reg    <= '0;
      shd_charge_reg <= '0;
      shd_valid_reg  <= 1'b0;
      act_ign_reg    <= '0;
      act_charge_reg <= '0;
      act_valid_reg  <= 1'b0;
      upd_pending    <= 1'b0;
      angle_err      <= 1'b0;
      coil_out       <= 1'b0;
      state_reg      <= ST_IDLE;
    end else begin
      // A strobe coinciding with a copy re-arms pending for the newer shadow.
      if (upd_strobe) begin
        shd_ign_reg    <= ign_angle;
        shd_charge_reg <= charge_new;
        shd_valid_reg  <= ign_ok;
        angle_err      <= !ign_ok;
        upd_pending    <= 1'b1;
      end else if (state_reg == ST_IDLE && upd_pending) begin
        upd_pending    <= 1'b0;
      end

      if (state_reg == ST_IDLE && upd_pending) begin
        act_ign_reg    <= shd_ign_reg;
        act_charge_reg <= shd_charge_reg;
        act_valid_reg  <= shd_valid_reg;
      end

      if (!hwag_start) begin
        state_reg <= ST_IDLE;
        coil_out  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // Zero dwell makes charge == ign; ignition wins, so no pulse.
            if (acnt_ena && act_valid_reg && ch_angle == act_charge_reg
                && ch_angle != act_ign_reg) begin
              state_reg <= ST_CHARGE;
              coil_out  <= 1'b1;
            end
          end
          ST_CHARGE: begin
            if (acnt_ena && ch_angle == act_ign_reg) begin
              state_reg <= ST_FIRE;
              coil_out  <= 1'b0;
            end
          end
          ST_FIRE: begin
            state_reg <= ST_IDLE;
            coil_out  <= 1'b0;
          end
          default: begin
            state_reg <= ST_IDLE;
            coil_out  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/hwag_coil_scheduler.sv
// N-channel ignition coil scheduler: slices per-channel phase offsets and
// instantiates one coil channel per output.
module hwag_coil_scheduler
  import hwag_coil_pkg::*;
#(
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int CHANNELS   = 2,
  parameter int ACNT_MAX   = ACNT_MAX_DEF
)
(
  input  logic                  clk,
  input  logic                  nrst,
  hwag_coil_scheduler_if.slave  bus
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      hwag_coil_channel #(
        .ACNT_WIDTH (ACNT_WIDTH),
        .ACNT_MAX   (ACNT_MAX)
      ) u_channel (
        .clk          (clk),
        .nrst         (nrst),
        .hwag_start   (bus.hwag_start),
        .acnt_ena     (bus.acnt_ena),
        .acnt_in      (bus.acnt_in),
        .phase_offset (bus.phase_offset[gi*ACNT_WIDTH +: ACNT_WIDTH]),
        .upd_strobe   (bus.upd_strobe),
        .ign_angle    (bus.ign_angle),
        .dwell_angle  (bus.dwell_angle),
        .coil_out     (bus.coil_out[gi]),
        .upd_pending  (bus.upd_pending[gi]),
        .angle_err    (bus.angle_err[gi])
      );
    end
  endgenerate

endmodule
